// File: rtl/mem_arb_defs_pkg.sv
// rtl/mem_arb_defs_pkg.sv - shared state/owner encodings and grant helper for mem_port_arbiter
package mem_arb_defs;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT_IF = 2'd1,
    ARB_WAIT_D  = 2'd2
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // On a tie the port that did not win last time gets the grant.
  function automatic logic pick_winner(input logic if_elig, input logic d_elig,
                                       input logic last_owner);
    if (if_elig && d_elig) return ~last_owner;
    else if (d_elig)       return OWN_D;
    else                   return OWN_IF;
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// rtl/mem_arb_timeout.sv - wait-cycle counter that flags an expired memory transaction
module mem_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wait_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!wait_i)     cnt_d = 8'd0;
    else if (!ack_i) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = wait_i && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for the shared memory port; MEM_ARB_TIMEOUT_EN enables abort on timeout
module mem_port_arbiter
  import mem_arb_defs::*;
#(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              owner,
  output logic              timeout_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  arb_state_e        state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              timeout_err_q, timeout_err_d;

  logic waiting, expired, if_elig, d_elig, winner;

  assign waiting = (state_q != ARB_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i     (clock),
    .rst_ni    (reset),
    .wait_i    (waiting),
    .ack_i     (mem_ack),
    .expired_o (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // A port whose done pulse is showing has not yet dropped its request.
  assign if_elig = if_req && !if_done_q;
  assign d_elig  = d_req && !d_done_q;
  assign winner  = pick_winner(if_elig, d_elig, last_owner_q);

  always_comb begin
    state_d       = state_q;
    last_owner_d  = last_owner_q;
    owner_d       = owner_q;
    busy_d        = busy_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    if_done_d     = 1'b0;
    d_done_d      = 1'b0;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ARB_IDLE: begin
        if (if_elig || d_elig) begin
          mem_req_d    = 1'b1;
          busy_d       = 1'b1;
          owner_d      = winner;
          last_owner_d = winner;
          if (winner == OWN_D) begin
            state_d     = ARB_WAIT_D;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_we_d    = d_we;
          end else begin
            state_d    = ARB_WAIT_IF;
            mem_addr_d = if_addr;
            mem_we_d   = 1'b0;
          end
        end
      end
      ARB_WAIT_IF, ARB_WAIT_D: begin
        if (mem_ack || expired) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          busy_d    = 1'b0;
          if (state_q == ARB_WAIT_D) d_done_d  = 1'b1;
          else                       if_done_d = 1'b1;
        end
        if (mem_ack) begin
          if (state_q == ARB_WAIT_IF) if_rdata_d = mem_rdata;
          else if (!mem_we_q)         d_rdata_d  = mem_rdata;
        end else if (expired) begin
          timeout_err_d = 1'b1;
          if (state_q == ARB_WAIT_D) d_rdata_d  = '1;
          else                       if_rdata_d = '1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ARB_IDLE;
      last_owner_q  <= OWN_D;
      owner_q       <= OWN_IF;
      busy_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      if_done_q     <= 1'b0;
      d_done_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_owner_q  <= last_owner_d;
      owner_q       <= owner_d;
      busy_q        <= busy_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      if_done_q     <= if_done_d;
      d_done_q      <= d_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign if_rdata    = if_rdata_q;
  assign if_done     = if_done_q;
  assign d_rdata     = d_rdata_q;
  assign d_done      = d_done_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic [63:0] if_rdata;
  logic        if_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic [63:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        owner;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          delay;
    logic [63:0] rdata;
    logic [63:0] exp_if;
    logic [63:0] exp_d;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_grant(input string name);
    int lat = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      lat++;
      if (mem_req) break;
    end
    check({name, "_grant_latency"}, 64'(lat), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string n = $sformatf("v%0d", idx);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    wait_grant(n);
    check({n, "_mem_addr"}, mem_addr, v.addr);
    check({n, "_mem_we"}, 64'(mem_we), 64'(v.is_d & v.we));
    check({n, "_owner"}, 64'(owner), 64'(v.is_d));
    check({n, "_busy"}, 64'(busy), 64'd1);
    if (v.is_d && v.we) check({n, "_mem_wdata"}, mem_wdata, v.wdata);
    repeat (v.delay) step();
    check({n, "_mem_req_held"}, 64'(mem_req), 64'd1);
    mem_ack = 1'b1; mem_rdata = v.rdata;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    check({n, "_if_done"}, 64'(if_done), 64'(!v.is_d));
    check({n, "_d_done"}, 64'(d_done), 64'(v.is_d));
    check({n, "_busy_after"}, 64'(busy), 64'd0);
    check({n, "_mem_req_after"}, 64'(mem_req), 64'd0);
    check({n, "_if_rdata"}, if_rdata, v.exp_if);
    check({n, "_d_rdata"}, d_rdata, v.exp_d);
    if_req = 1'b0; d_req = 1'b0;
    step();
    check({n, "_done_one_cycle"}, 64'({if_done, d_done}), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 64'h40,  64'h0,     3, 64'h8B020020,
                64'h8B020020, 64'h0};
    vecs[1] = '{1'b1, 1'b1, 64'h100, 64'hDEAD,  0, 64'h5555,
                64'h8B020020, 64'h0};
    vecs[2] = '{1'b1, 1'b0, 64'h108, 64'h0,     1, 64'h123456789ABCDEF0,
                64'h8B020020, 64'h123456789ABCDEF0};
    vecs[3] = '{1'b1, 1'b1, 64'h110, 64'hFFFF_FFFF_FFFF_FFFF, 2, 64'h77,
                64'h8B020020, 64'h123456789ABCDEF0};
    vecs[4] = '{1'b0, 1'b0, 64'h44,  64'h0,     0, 64'h91000421,
                64'h91000421, 64'h123456789ABCDEF0};

    repeat (2) step();
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_rdata", if_rdata | d_rdata, 64'd0);
    check("rst_done", 64'({if_done, d_done}), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Reset while a data transaction waits for its ack.
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h180;
    wait_grant("rstwait");
    check("rstwait_owner", 64'(owner), 64'd1);
    #2 reset = 1'b0; d_req = 1'b0;
    #1;
    check("rstwait_mem_req_async", 64'(mem_req), 64'd0);
    check("rstwait_busy_async", 64'(busy), 64'd0);
    step();
    reset = 1'b1;
    step();
    step();
    check("rstwait_no_d_done", 64'(d_done), 64'd0);
    check("rstwait_idle", 64'({busy, mem_req}), 64'd0);

    // Contention from reset: fetch first, then alternate.
    if_req = 1'b1; if_addr = 64'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300;
    wait_grant("cont1");
    check("cont1_owner", 64'(owner), 64'd0);
    check("cont1_addr", mem_addr, 64'h200);
    mem_ack = 1'b1; mem_rdata = 64'hAAAA;
    step();
    mem_ack = 1'b0;
    check("cont1_if_done", 64'(if_done), 64'd1);
    check("cont1_if_rdata", if_rdata, 64'hAAAA);
    step();
    check("cont2_regrant", 64'(mem_req), 64'd1);
    check("cont2_owner", 64'(owner), 64'd1);
    check("cont2_addr", mem_addr, 64'h300);
    mem_ack = 1'b1; mem_rdata = 64'hBBBB;
    step();
    mem_ack = 1'b0;
    check("cont2_d_done", 64'(d_done), 64'd1);
    check("cont2_d_rdata", d_rdata, 64'hBBBB);
    step();
    check("cont3_owner", 64'(owner), 64'd0);
    check("cont3_addr", mem_addr, 64'h200);
    check("cont3_mem_req", 64'(mem_req), 64'd1);
    d_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 64'hCCCC;
    step();
    mem_ack = 1'b0;
    check("cont3_if_done", 64'(if_done), 64'd1);
    check("cont3_if_rdata", if_rdata, 64'hCCCC);
    if_req = 1'b0;
    step();
    check("cont_end_idle", 64'({busy, mem_req}), 64'd0);

    // Stray acknowledge while idle.
    mem_ack = 1'b1; mem_rdata = 64'hFFFF;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stray_done", 64'({if_done, d_done}), 64'd0);
      check("stray_busy", 64'({busy, mem_req}), 64'd0);
      check("stray_if_rdata", if_rdata, 64'hCCCC);
      check("stray_d_rdata", d_rdata, 64'hBBBB);
    end
    mem_ack = 1'b0; mem_rdata = '0;
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int edges = 0;
      if_req = 1'b1; if_addr = 64'h80;
      wait_grant("tmo");
      for (int i = 0; i < 20; i++) begin
        step();
        edges++;
        if (if_done) break;
      end
      check("tmo_edges_to_abort", 64'(edges), 64'd5);
      check("tmo_if_done", 64'(if_done), 64'd1);
      check("tmo_if_rdata", if_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
      check("tmo_err", 64'(timeout_err), 64'd1);
      check("tmo_mem_req", 64'(mem_req), 64'd0);
      if_req = 1'b0;
      repeat (3) step();
      check("tmo_err_sticky", 64'(timeout_err), 64'd1);
    end
`else
    check("no_timeout_err", 64'(timeout_err), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
